vend_control_multi: RTL and testbench

- Parametrised successor to the single-product candy controller. Serves NUM_ITEMS products with per-item prices, two coin denominations and a credit ceiling.
- Change is paid out as timed unit pulses. A saturating sold-item counter covers the current session.
- Sits between the debounced coin/button front end and the dispense/display drivers.

---
 rtl/vend_control_multi.sv | 250 +++++++++++++++++++++++++
 tb/tb_vend_control_multi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_control_multi.sv
// ---------------------------------------------------------------------------
// vend_control_multi
//
// Multi-product vending controller. Accepts two coin denominations up to a
// credit ceiling, sells NUM_ITEMS products (item k costs PRICE_STEP*(k+1)),
// pays change back as timed unit pulses and counts items sold in the current
// session (cleared when a change payout completes).
//
// Optional feature (macro VEND_BIG_CHANGE_EN):
//   defined   - change is paid in COIN_B units (change_b_pulse) while the
//               credit allows, then in COIN_A units (change_pulse).
//   undefined - only COIN_A units are paid; change_b_pulse is tied low.
//
// Handshake: every input strobe is a one-cycle pulse sampled on the rising
// clock edge; every output strobe is a registered one-cycle pulse that
// appears in the cycle after the edge that accepted or refused the event.
//
// Ports:
//   clk            in   clock, rising edge
//   a_reset        in   asynchronous, active-high reset
//   coin_a         in   small coin inserted (pulse)
//   coin_b         in   large coin inserted (pulse)
//   vend_req       in   purchase request (pulse)
//   vend_sel       in   product index, sampled with vend_req
//   change_req     in   return remaining credit (pulse)
//   credit         out  current credit
//   can_buy        out  bit k set when credit covers price of item k
//   vend_pulse     out  dispense strobe
//   vend_item      out  index dispensed, valid with vend_pulse
//   vend_denied    out  request refused strobe
//   coin_reject    out  coin returned strobe
//   change_pulse   out  one strobe per COIN_A unit returned
//   change_b_pulse out  one strobe per COIN_B unit returned
//   busy           out  high while paying change
//   sold_count     out  items vended this session, saturating
// ---------------------------------------------------------------------------
module vend_control_multi #(
    parameter int CREDIT_W     = 4,
    parameter int MAX_CREDIT   = 15,
    parameter int COIN_A       = 1,
    parameter int COIN_B       = 5,
    parameter int NUM_ITEMS    = 4,
    parameter int SEL_W        = 2,
    parameter int PRICE_STEP   = 2,
    parameter int CHANGE_TICKS = 2,
    parameter int COUNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 a_reset,
    input  logic                 coin_a,
    input  logic                 coin_b,
    input  logic                 vend_req,
    input  logic [SEL_W-1:0]     vend_sel,
    input  logic                 change_req,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] can_buy,
    output logic                 vend_pulse,
    output logic [SEL_W-1:0]     vend_item,
    output logic                 vend_denied,
    output logic                 coin_reject,
    output logic                 change_pulse,
    output logic                 change_b_pulse,
    output logic                 busy,
    output logic [COUNT_W-1:0]   sold_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam int CW1    = CREDIT_W + 1;
    localparam int TICK_W = (CHANGE_TICKS > 1) ? $clog2(CHANGE_TICKS) : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(CHANGE_TICKS - 1);
    localparam logic [CREDIT_W-1:0] CRED_A    = CREDIT_W'(COIN_A);
    localparam logic [CREDIT_W:0]   MAX_W     = CW1'(MAX_CREDIT);

    state_t              state, state_n;
    logic [TICK_W-1:0]   tick, tick_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [COUNT_W-1:0]  sold_n;
    logic [SEL_W-1:0]    vend_item_n;
    logic                vend_pulse_n, vend_denied_n, coin_reject_n;
    logic                change_pulse_n, change_b_n, busy_n;

    // Coin sums carry one extra bit so an over-ceiling coin can never wrap
    // around into an apparently small credit.
    logic [CREDIT_W:0] sum_a, sum_b;
    logic [31:0]       price;
    logic              sel_ok, price_ok;

    assign sum_a    = {1'b0, credit} + CW1'(COIN_A);
    assign sum_b    = {1'b0, credit} + CW1'(COIN_B);
    assign price    = 32'(PRICE_STEP) * (32'(vend_sel) + 32'd1);
    assign sel_ok   = (32'(vend_sel) < 32'(NUM_ITEMS));
    assign price_ok = (32'(credit) >= price);

    // Affordability flags follow the credit register directly.
    always_comb begin
        can_buy = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            can_buy[k] = (32'(credit) >= 32'(PRICE_STEP * (k + 1)));
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n        = state;
        tick_n         = tick;
        credit_n       = credit;
        sold_n         = sold_count;
        vend_item_n    = vend_item;
        vend_pulse_n   = 1'b0;
        vend_denied_n  = 1'b0;
        coin_reject_n  = 1'b0;
        change_pulse_n = 1'b0;
        change_b_n     = 1'b0;

        case (state)
            ST_IDLE, ST_CREDIT: begin
                // One event per cycle: change_req > vend_req > coin_b > coin_a.
                // A change request with no credit is not an event at all.
                if (change_req && (state == ST_CREDIT)) begin
                    state_n = ST_CHANGE;
                    tick_n  = '0;
                    if (coin_a || coin_b) begin
                        coin_reject_n = 1'b1;
                    end
                end else if (vend_req) begin
                    if (sel_ok && price_ok) begin
                        credit_n     = credit - price[CREDIT_W-1:0];
                        vend_pulse_n = 1'b1;
                        vend_item_n  = vend_sel;
                        if (sold_count != '1) begin
                            sold_n = sold_count + 1'b1;
                        end
                        state_n = (credit_n == '0) ? ST_IDLE : ST_CREDIT;
                    end else begin
                        vend_denied_n = 1'b1;
                    end
                    if (coin_a || coin_b) begin
                        coin_reject_n = 1'b1;
                    end
                end else if (coin_b) begin
                    if (sum_b <= MAX_W) begin
                        credit_n = sum_b[CREDIT_W-1:0];
                        state_n  = ST_CREDIT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                    // A simultaneous small coin lost arbitration.
                    if (coin_a) begin
                        coin_reject_n = 1'b1;
                    end
                end else if (coin_a) begin
                    if (sum_a <= MAX_W) begin
                        credit_n = sum_a[CREDIT_W-1:0];
                        state_n  = ST_CREDIT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
            end

            ST_CHANGE: begin
                if (vend_req) begin
                    vend_denied_n = 1'b1;
                end
                if (coin_a || coin_b) begin
                    coin_reject_n = 1'b1;
                end
                if (tick == TICK_LAST) begin
                    tick_n = '0;
`ifdef VEND_BIG_CHANGE_EN
                    if (32'(credit) >= 32'(COIN_B)) begin
                        change_b_n = 1'b1;
                        credit_n   = credit - CREDIT_W'(COIN_B);
                    end else begin
                        change_pulse_n = 1'b1;
                        credit_n       = (credit > CRED_A) ? (credit - CRED_A) : '0;
                    end
`else
                    change_pulse_n = 1'b1;
                    credit_n       = (credit > CRED_A) ? (credit - CRED_A) : '0;
`endif
                    // Payout complete ends the session.
                    if (credit_n == '0) begin
                        state_n = ST_IDLE;
                        sold_n  = '0;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end

            default: begin
                state_n  = ST_IDLE;
                credit_n = '0;
                tick_n   = '0;
            end
        endcase

        busy_n = (state_n == ST_CHANGE);
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state        <= ST_IDLE;
            tick         <= '0;
            credit       <= '0;
            sold_count   <= '0;
            vend_item    <= '0;
            vend_pulse   <= 1'b0;
            vend_denied  <= 1'b0;
            coin_reject  <= 1'b0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            tick         <= tick_n;
            credit       <= credit_n;
            sold_count   <= sold_n;
            vend_item    <= vend_item_n;
            vend_pulse   <= vend_pulse_n;
            vend_denied  <= vend_denied_n;
            coin_reject  <= coin_reject_n;
            change_pulse <= change_pulse_n;
            busy         <= busy_n;
        end
    end

`ifdef VEND_BIG_CHANGE_EN
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            change_b_pulse <= 1'b0;
        end else begin
            change_b_pulse <= change_b_n;
        end
    end
`else
    assign change_b_pulse = 1'b0;

    // The large-coin payout path does not exist in this build.
    logic unused_change_b;
    assign unused_change_b = change_b_n;
`endif

endmodule

// File: tb/tb_vend_control_multi.sv
// ---------------------------------------------------------------------------
// tb_vend_control_multi
//
// Self-checking bench for vend_control_multi. A behavioural model tracks
// credit, payout progress and session count with plain integers and is
// compared against the DUT on every falling edge. Directed sequences with
// hand-computed literal expectations are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_vend_control_multi;
  localparam int CREDIT_W     = 4;
  localparam int MAX_CREDIT   = 15;
  localparam int COIN_A       = 1;
  localparam int COIN_B       = 5;
  localparam int NUM_ITEMS    = 4;
  localparam int SEL_W        = 2;
  localparam int PRICE_STEP   = 2;
  localparam int CHANGE_TICKS = 2;
  localparam int COUNT_W      = 3;
`ifdef VEND_BIG_CHANGE_EN
  localparam bit BIG = 1'b1;
`else
  localparam bit BIG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic a_reset;
  logic coin_a, coin_b, vend_req, change_req;
  logic [SEL_W-1:0] vend_sel;

  logic [CREDIT_W-1:0]  credit;
  logic [NUM_ITEMS-1:0] can_buy;
  logic                 vend_pulse, vend_denied, coin_reject;
  logic                 change_pulse, change_b_pulse, busy;
  logic [SEL_W-1:0]     vend_item;
  logic [COUNT_W-1:0]   sold_count;

  always #5 clk = ~clk;

  vend_control_multi #(
    .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT), .COIN_A(COIN_A),
    .COIN_B(COIN_B), .NUM_ITEMS(NUM_ITEMS), .SEL_W(SEL_W),
    .PRICE_STEP(PRICE_STEP), .CHANGE_TICKS(CHANGE_TICKS), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .a_reset(a_reset), .coin_a(coin_a), .coin_b(coin_b),
    .vend_req(vend_req), .vend_sel(vend_sel), .change_req(change_req),
    .credit(credit), .can_buy(can_buy), .vend_pulse(vend_pulse),
    .vend_item(vend_item), .vend_denied(vend_denied),
    .coin_reject(coin_reject), .change_pulse(change_pulse),
    .change_b_pulse(change_b_pulse), .busy(busy), .sold_count(sold_count)
  );

  // ---------------- counters / check helper ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_credit, m_sold, m_cnt;
  bit m_paying;
  bit e_vend, e_denied, e_reject, e_chg, e_chgb;
  int e_item;

  always @(posedge clk or posedge a_reset) begin
    bit taken;
    int price;
    e_vend = 0; e_denied = 0; e_reject = 0; e_chg = 0; e_chgb = 0;
    if (a_reset) begin
      m_credit = 0; m_sold = 0; m_cnt = 0; m_paying = 0; e_item = 0;
    end else if (m_paying) begin
      if (vend_req) e_denied = 1;
      if (coin_a || coin_b) e_reject = 1;
      m_cnt++;
      if (m_cnt == CHANGE_TICKS) begin
        m_cnt = 0;
        if (BIG && m_credit >= COIN_B) begin
          e_chgb = 1; m_credit -= COIN_B;
        end else begin
          e_chg = 1; m_credit -= (m_credit < COIN_A) ? m_credit : COIN_A;
        end
        if (m_credit == 0) begin
          m_paying = 0; m_sold = 0;
        end
      end
    end else begin
      taken = 0;
      if (change_req && m_credit > 0) begin
        m_paying = 1; m_cnt = 0; taken = 1;
      end else if (vend_req) begin
        taken = 1;
        price = PRICE_STEP * (int'(vend_sel) + 1);
        if (int'(vend_sel) < NUM_ITEMS && m_credit >= price) begin
          m_credit -= price; e_vend = 1; e_item = int'(vend_sel);
          if (m_sold < (1 << COUNT_W) - 1) m_sold++;
        end else begin
          e_denied = 1;
        end
      end
      // Coins in arbitration order; a coin seeing the slot taken is returned.
      if (coin_b) begin
        if (taken) e_reject = 1;
        else begin
          taken = 1;
          if (m_credit + COIN_B <= MAX_CREDIT) m_credit += COIN_B;
          else e_reject = 1;
        end
      end
      if (coin_a) begin
        if (taken) e_reject = 1;
        else begin
          taken = 1;
          if (m_credit + COIN_A <= MAX_CREDIT) m_credit += COIN_A;
          else e_reject = 1;
        end
      end
    end
  end

  function automatic logic [31:0] model_can_buy();
    logic [31:0] v = '0;
    for (int k = 0; k < NUM_ITEMS; k++) v[k] = (m_credit >= PRICE_STEP * (k + 1));
    return v;
  endfunction

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("credit", 32'(credit), 32'(m_credit));
      chk("can_buy", 32'(can_buy), model_can_buy());
      chk("vend_pulse", 32'(vend_pulse), 32'(e_vend));
      if (e_vend) chk("vend_item", 32'(vend_item), 32'(e_item));
      chk("vend_denied", 32'(vend_denied), 32'(e_denied));
      chk("coin_reject", 32'(coin_reject), 32'(e_reject));
      chk("change_pulse", 32'(change_pulse), 32'(e_chg));
      chk("change_b_pulse", 32'(change_b_pulse), 32'(e_chgb));
      chk("busy", 32'(busy), 32'(m_paying));
      chk("sold_count", 32'(sold_count), 32'(m_sold));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; applies one cycle of inputs and returns at the
  // next falling edge, when the outputs reflect the edge in between.
  task automatic drive(input logic ca, input logic cb, input logic vr,
                       input logic [SEL_W-1:0] sel, input logic cr);
    coin_a = ca; coin_b = cb; vend_req = vr; vend_sel = sel; change_req = cr;
    @(negedge clk);
    coin_a = 0; coin_b = 0; vend_req = 0; change_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_reset = 0; coin_a = 0; coin_b = 0; vend_req = 0; vend_sel = 0; change_req = 0;
    #1 a_reset = 1;
    repeat (2) @(negedge clk);
    a_reset = 0;
    chk_en = 1;

    // reset state
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sold", 32'(sold_count), 0);
    chk("rst_can_buy", 32'(can_buy), 0);

    // coins: 5, 6, 7
    drive(0, 1, 0, 0, 0); chk("lit_credit5", 32'(credit), 5);
    drive(1, 0, 0, 0, 0); chk("lit_credit6", 32'(credit), 6);
    drive(1, 0, 0, 0, 0); chk("lit_credit7", 32'(credit), 7);
    chk("lit_can_buy7", 32'(can_buy), 32'b0111);

    // too expensive: item 3 costs 8
    drive(0, 0, 1, 2'd3, 0);
    chk("lit_denied", 32'(vend_denied), 1);
    chk("lit_credit_hold", 32'(credit), 7);

    // item 2 costs 6
    drive(0, 0, 1, 2'd2, 0);
    chk("lit_vend", 32'(vend_pulse), 1);
    chk("lit_item", 32'(vend_item), 2);
    chk("lit_credit1", 32'(credit), 1);
    chk("lit_sold1", 32'(sold_count), 1);

    // up to 12, then an over-ceiling coin
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0);
    chk("lit_credit12", 32'(credit), 12);
    drive(0, 1, 0, 0, 0);
    chk("lit_ceiling_reject", 32'(coin_reject), 1);
    chk("lit_credit12_hold", 32'(credit), 12);

    // vend beats coin_a in the same cycle
    drive(1, 0, 1, 2'd0, 0);
    chk("lit_arb_vend", 32'(vend_pulse), 1);
    chk("lit_arb_reject", 32'(coin_reject), 1);
    chk("lit_credit10", 32'(credit), 10);

    // down to 3, then change out
    drive(0, 0, 1, 2'd3, 0); drive(1, 0, 0, 0, 0);
    chk("lit_credit3", 32'(credit), 3);
    drive(0, 0, 0, 0, 1);
    chk("lit_busy", 32'(busy), 1);
    for (int p = 0; p < 3; p++) begin
      idle(1);
      chk("lit_chg_gap", 32'(change_pulse), 0);
      idle(1);
      chk("lit_chg_pulse", 32'(change_pulse), 1);
      chk("lit_chg_credit", 32'(credit), 32'(2 - p));
    end
    chk("lit_chg_done_busy", 32'(busy), 0);
    chk("lit_chg_done_sold", 32'(sold_count), 0);

`ifdef VEND_BIG_CHANGE_EN
    drive(0, 1, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    idle(2);
    chk("lit_big_b", 32'(change_b_pulse), 1);
    chk("lit_big_credit2", 32'(credit), 2);
    idle(2);
    chk("lit_big_a1", 32'(change_pulse), 1);
    idle(2);
    chk("lit_big_a2", 32'(change_pulse), 1);
    chk("lit_big_credit0", 32'(credit), 0);
`endif

    // reset in the middle of a payout
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    idle(2);
    #2 a_reset = 1;
    #1;
    chk("lit_midrst_credit", 32'(credit), 0);
    chk("lit_midrst_busy", 32'(busy), 0);
    @(negedge clk);
    #2 a_reset = 0;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 a_reset = 1;
        @(negedge clk);
        #2 a_reset = 0;
        @(negedge clk);
      end else begin
        coin_a     = ($urandom_range(0, 3) == 0);
        coin_b     = ($urandom_range(0, 6) == 0);
        vend_req   = ($urandom_range(0, 5) == 0);
        vend_sel   = SEL_W'($urandom_range(0, NUM_ITEMS - 1));
        change_req = ($urandom_range(0, 24) == 0);
        @(negedge clk);
      end
    end
    coin_a = 0; coin_b = 0; vend_req = 0; change_req = 0;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
